// File: rtl/fta_bus_pkg.sv
// FTA 128-bit command bus types shared by the bus masters and the master-side arbiter.
//   fta_tranid_t          : transaction id; channel routes responses back to a requester
//   fta_cmd_request128_t  : command from a master (cyc qualifies the whole record)
//   fta_cmd_response128_t : response / retry towards a master
//   arb_mode_e            : arbiter policy (fixed priority or round robin)
package fta_bus_pkg;

   localparam int unsigned FtaChanW = 3;

   typedef enum logic {
      ARB_FIXED = 1'b0,
      ARB_RR    = 1'b1
   } arb_mode_e;

   typedef struct packed {
      logic [FtaChanW-1:0] channel;
      logic [7:0]          tranid;
   } fta_tranid_t;

   typedef struct packed {
      logic          cyc;
      logic          we;
      logic [15:0]   sel;
      logic [31:0]   adr;
      logic [127:0]  dat;
      fta_tranid_t   tid;
   } fta_cmd_request128_t;

   typedef struct packed {
      logic          ack;
      logic          rty;
      logic          err;
      fta_tranid_t   tid;
      logic [31:0]   adr;
      logic [127:0]  dat;
   } fta_cmd_response128_t;

   // Increment a channel index, wrapping n-1 -> 0.
   function automatic logic [FtaChanW-1:0] wrap_inc(input logic [FtaChanW-1:0] v,
                                                     input int unsigned n);
      if (32'(v) + 32'd1 >= n) return '0;
      return v + 1'b1;
   endfunction

endpackage

// File: rtl/fta_rr_sel.sv
// Rotating-priority selector: first set request at or after i_ptr, wrapping N-1 -> 0.
//   i_req    : request vector, one bit per channel
//   i_ptr    : index with highest priority (tie to 0 for fixed priority)
//   o_onehot : winner as a one-hot vector
//   o_idx    : winner index
//   o_any    : at least one request present
module fta_rr_sel #(
   parameter int unsigned N = 5
) (
   input  logic [N-1:0] i_req,
   input  logic [2:0]   i_ptr,
   output logic [N-1:0] o_onehot,
   output logic [2:0]   o_idx,
   output logic         o_any
);

   always_comb begin
      o_onehot = '0;
      o_idx    = '0;
      o_any    = 1'b0;
      // First pass covers [ptr, N-1], second pass wraps around to [0, ptr-1].
      for (int i = 0; i < N; i++) begin
         if (!o_any && i_req[i] && (32'(i) >= 32'(i_ptr))) begin
            o_any       = 1'b1;
            o_onehot[i] = 1'b1;
            o_idx       = 3'(i);
         end
      end
      for (int i = 0; i < N; i++) begin
         if (!o_any && i_req[i] && (32'(i) < 32'(i_ptr))) begin
            o_any       = 1'b1;
            o_onehot[i] = 1'b1;
            o_idx       = 3'(i);
         end
      end
   end

endmodule

// File: rtl/fta_bus_arbiter.sv
// Master-side arbiter for the FTA 128-bit command bus.
//   clk, rst   : clock, asynchronous active-low reset
//   req_i      : per-channel commands (index == tid.channel)
//   resp_o     : per-channel responses; retry for every channel not granted this cycle
//   fta_req    : registered winning command towards the bus
//   fta_resp   : response from the bus, routed back by tid.channel
//   owner_o    : current owner index, valid when owner_v_o
//   owner_v_o  : bus currently owned
//   misroute_o : one-cycle pulse after an ack whose tid.channel has no port
module fta_bus_arbiter
   import fta_bus_pkg::*;
#(
   parameter int unsigned CHANNELS = 5,
   parameter arb_mode_e   MODE     = ARB_FIXED,
   parameter int unsigned HOLD_MAX = 16
) (
   input  logic                 clk,
   input  logic                 rst,
   input  fta_cmd_request128_t  req_i  [CHANNELS],
   output fta_cmd_response128_t resp_o [CHANNELS],
   output fta_cmd_request128_t  fta_req,
   input  fta_cmd_response128_t fta_resp,
   output logic [2:0]           owner_o,
   output logic                 owner_v_o,
   output logic                 misroute_o
);

   localparam int unsigned HoldW = (HOLD_MAX < 2) ? 1 : $clog2(HOLD_MAX + 1);
   // With no limit the counter simply saturates at all-ones and is never consulted.
   localparam logic [HoldW-1:0] HoldLim = (HOLD_MAX == 0) ? '1 : HoldW'(HOLD_MAX);

   logic                r_owner_v;
   logic [2:0]          r_owner;
   logic [2:0]          r_rr_ptr;
   logic [HoldW-1:0]    r_hold_cnt;
   fta_cmd_request128_t r_fta_req;
   logic                r_misroute;

   logic                w_owner_v_nxt;
   logic [2:0]          w_owner_nxt;
   logic [2:0]          w_rr_ptr_nxt;
   logic [HoldW-1:0]    w_hold_nxt;
   fta_cmd_request128_t w_fta_req_nxt;
   logic                w_misroute_nxt;

   logic [CHANNELS-1:0] w_cyc;
   logic [CHANNELS-1:0] w_owner_oh;
   logic [CHANNELS-1:0] w_cand;
   logic [CHANNELS-1:0] w_win_oh;
   logic [CHANNELS-1:0] w_sel_oh;
   logic [2:0]          w_win_idx;
   logic [2:0]          w_ptr;
   logic                w_win_any;
   logic                w_others;
   logic                w_timeout;
   logic                w_keep;
   logic                w_sel_v;
   fta_cmd_request128_t w_sel_req;

   always_comb begin
      w_cyc      = '0;
      w_owner_oh = '0;
      for (int i = 0; i < CHANNELS; i++) begin
         w_cyc[i]      = req_i[i].cyc;
         w_owner_oh[i] = r_owner_v && (r_owner == 3'(i));
      end
   end

   assign w_others  = |(w_cyc & ~w_owner_oh);
   assign w_timeout = (HOLD_MAX != 0) && r_owner_v && (r_hold_cnt == HoldLim) && w_others;
   assign w_keep    = (|(w_cyc & w_owner_oh)) && !w_timeout;
   // A timed-out owner sits out exactly this one arbitration round.
   assign w_cand    = w_timeout ? (w_cyc & ~w_owner_oh) : w_cyc;
   assign w_ptr     = (MODE == ARB_RR) ? r_rr_ptr : 3'd0;

   fta_rr_sel #(
      .N (CHANNELS)
   ) u_sel (
      .i_req    (w_cand),
      .i_ptr    (w_ptr),
      .o_onehot (w_win_oh),
      .o_idx    (w_win_idx),
      .o_any    (w_win_any)
   );

   // Selection is combinational so a handover costs no idle cycle.
   assign w_sel_v  = w_keep || w_win_any;
   assign w_sel_oh = w_keep ? w_owner_oh : w_win_oh;

   always_comb begin
      w_sel_req = '0;
      for (int i = 0; i < CHANNELS; i++) begin
         if (w_sel_oh[i]) w_sel_req = req_i[i];
      end
   end

   always_comb begin
      w_owner_v_nxt = r_owner_v;
      w_owner_nxt   = r_owner;
      w_rr_ptr_nxt  = r_rr_ptr;
      w_hold_nxt    = r_hold_cnt;
      if (w_keep) begin
         if (r_hold_cnt != HoldLim) w_hold_nxt = r_hold_cnt + 1'b1;
      end else if (w_win_any) begin
         w_owner_v_nxt = 1'b1;
         w_owner_nxt   = w_win_idx;
         w_hold_nxt    = HoldW'(1);
         w_rr_ptr_nxt  = wrap_inc(w_win_idx, CHANNELS);
      end else begin
         w_owner_v_nxt = 1'b0;
      end
      // A retried command is dropped; the master reissues it.
      w_fta_req_nxt  = (w_sel_v && !fta_resp.rty) ? w_sel_req : '0;
      w_misroute_nxt = fta_resp.ack && ({29'd0, fta_resp.tid.channel} >= CHANNELS);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_owner_v  <= 1'b0;
         r_owner    <= '0;
         r_rr_ptr   <= '0;
         r_hold_cnt <= '0;
         r_fta_req  <= '0;
         r_misroute <= 1'b0;
      end else begin
         r_owner_v  <= w_owner_v_nxt;
         r_owner    <= w_owner_nxt;
         r_rr_ptr   <= w_rr_ptr_nxt;
         r_hold_cnt <= w_hold_nxt;
         r_fta_req  <= w_fta_req_nxt;
         r_misroute <= w_misroute_nxt;
      end
   end

   // Responses: retry by default, downstream stall for the selected channel, and an ack
   // addressed to a channel overrides everything (split transactions need no ownership).
   always_comb begin
      for (int i = 0; i < CHANNELS; i++) begin
         resp_o[i]     = '0;
         resp_o[i].rty = 1'b1;
         resp_o[i].tid = req_i[i].tid;
         if (w_sel_oh[i]) begin
            resp_o[i].rty = fta_resp.rty;
            resp_o[i].tid = '0;
         end
         if (fta_resp.ack && (fta_resp.tid.channel == 3'(i))) resp_o[i] = fta_resp;
      end
   end

   assign fta_req    = r_fta_req;
   assign owner_o    = r_owner;
   assign owner_v_o  = r_owner_v;
   assign misroute_o = r_misroute;

endmodule

// File: tb/tb_fta_bus_arbiter.sv
// Directed bench for fta_bus_arbiter: a fixed-priority and a round-robin instance
// (both CHANNELS=5, HOLD_MAX=4) driven from vector tables plus hand-written sequences.
module tb_fta_bus_arbiter;
   import fta_bus_pkg::*;

   localparam int unsigned NCH = 5;

   typedef struct packed {
      logic [4:0] cyc;    // cyc per channel this cycle
      logic [4:0] rty;    // expected resp_o[i].rty this cycle
      logic       ov;     // expected owner_v_o after the edge
      logic [2:0] own;    // expected owner_o after the edge (when ov)
      logic       fcyc;   // expected fta_req carries a command after the edge
      logic [2:0] fch;    // channel whose command fta_req carries
   } vec_t;

   logic clk = 1'b0;
   logic rst = 1'b0;

   fta_cmd_request128_t  req_f  [NCH];
   fta_cmd_request128_t  req_r  [NCH];
   fta_cmd_response128_t resp_f [NCH];
   fta_cmd_response128_t resp_r [NCH];
   fta_cmd_request128_t  freq_f, freq_r;
   fta_cmd_response128_t fresp;
   logic [2:0]           own_f, own_r;
   logic                 ov_f, ov_r, mis_f, mis_r;

   int total = 0;
   int bad   = 0;

   vec_t tf [18];
   vec_t tr [9];

   always #5 clk = ~clk;

   fta_bus_arbiter #(
      .CHANNELS (NCH),
      .MODE     (ARB_FIXED),
      .HOLD_MAX (4)
   ) u_fix (
      .clk        (clk),
      .rst        (rst),
      .req_i      (req_f),
      .resp_o     (resp_f),
      .fta_req    (freq_f),
      .fta_resp   (fresp),
      .owner_o    (own_f),
      .owner_v_o  (ov_f),
      .misroute_o (mis_f)
   );

   fta_bus_arbiter #(
      .CHANNELS (NCH),
      .MODE     (ARB_RR),
      .HOLD_MAX (4)
   ) u_rr (
      .clk        (clk),
      .rst        (rst),
      .req_i      (req_r),
      .resp_o     (resp_r),
      .fta_req    (freq_r),
      .fta_resp   (fresp),
      .owner_o    (own_r),
      .owner_v_o  (ov_r),
      .misroute_o (mis_r)
   );

   function automatic fta_cmd_request128_t mk_req(input int ch, input int row, input logic cyc);
      fta_cmd_request128_t r;
      r             = '0;
      r.cyc         = cyc;
      r.we          = ((ch % 2) == 1);
      r.sel         = 16'hFFFF;
      r.adr         = 32'h1000_0000 + 32'(row * 256 + ch * 16);
      r.dat         = {4{32'hA500_0000 + 32'(row * 16 + ch)}};
      r.tid.channel = 3'(ch);
      r.tid.tranid  = 8'(row);
      return r;
   endfunction

   function automatic vec_t mkv(input logic [4:0] cyc, input logic [4:0] rty, input logic ov,
                                input int own, input logic fcyc, input int fch);
      vec_t v;
      v.cyc  = cyc;
      v.rty  = rty;
      v.ov   = ov;
      v.own  = 3'(own);
      v.fcyc = fcyc;
      v.fch  = 3'(fch);
      return v;
   endfunction

   task automatic chk(input string name, input logic [255:0] got, input logic [255:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h", name, got, exp);
      end
   endtask

   task automatic drive(input bit rr, input logic [4:0] cyc, input int row);
      for (int i = 0; i < NCH; i++) begin
         if (rr) req_r[i] = mk_req(i, row, cyc[i]);
         else    req_f[i] = mk_req(i, row, cyc[i]);
      end
   endtask

   task automatic run_row(input bit rr, input vec_t v, input int row, input string tag);
      logic [4:0]  got_rty;
      logic [54:0] got_tid, exp_tid;
      fta_cmd_request128_t exp_req;
      @(negedge clk);
      drive(rr, v.cyc, row);
      #1;
      for (int i = 0; i < NCH; i++) begin
         fta_tranid_t t;
         t                 = mk_req(i, row, 1'b1).tid;
         got_rty[i]        = rr ? resp_r[i].rty : resp_f[i].rty;
         got_tid[i*11 +: 11] = rr ? resp_r[i].tid : resp_f[i].tid;
         exp_tid[i*11 +: 11] = v.rty[i] ? t : 11'd0;
      end
      chk($sformatf("%s r%0d rty", tag, row), 256'(got_rty), 256'(v.rty));
      chk($sformatf("%s r%0d tid", tag, row), 256'(got_tid), 256'(exp_tid));
      @(posedge clk);
      #1;
      chk($sformatf("%s r%0d owner_v", tag, row), 256'(rr ? ov_r : ov_f), 256'(v.ov));
      if (v.ov) chk($sformatf("%s r%0d owner", tag, row), 256'(rr ? own_r : own_f), 256'(v.own));
      exp_req = v.fcyc ? mk_req(int'(v.fch), row, 1'b1) : '0;
      chk($sformatf("%s r%0d fta_req", tag, row), 256'(rr ? freq_r : freq_f), 256'(exp_req));
   endtask

   initial begin
      logic [4:0] acks;

      // Fixed priority, HOLD_MAX=4.
      tf[0]  = mkv(5'b00101, 5'b11110, 1, 0, 1, 0);  // ch0 beats ch2
      tf[1]  = mkv(5'b00100, 5'b11011, 1, 2, 1, 2);  // gapless handover to ch2
      tf[2]  = mkv(5'b00000, 5'b11111, 0, 0, 0, 0);
      tf[3]  = mkv(5'b01010, 5'b11101, 1, 1, 1, 1);  // ch1 streams, ch3 waits
      tf[4]  = mkv(5'b01010, 5'b11101, 1, 1, 1, 1);
      tf[5]  = mkv(5'b01010, 5'b11101, 1, 1, 1, 1);
      tf[6]  = mkv(5'b01010, 5'b11101, 1, 1, 1, 1);
      tf[7]  = mkv(5'b01010, 5'b10111, 1, 3, 1, 3);  // 5th cycle: ch1 timed out
      tf[8]  = mkv(5'b00010, 5'b11101, 1, 1, 1, 1);  // ch1 resumes
      tf[9]  = mkv(5'b00010, 5'b11101, 1, 1, 1, 1);
      tf[10] = mkv(5'b00000, 5'b11111, 0, 0, 0, 0);
      tf[11] = mkv(5'b00010, 5'b11101, 1, 1, 1, 1);  // alone: no timeout, count saturates
      tf[12] = mkv(5'b00010, 5'b11101, 1, 1, 1, 1);
      tf[13] = mkv(5'b00010, 5'b11101, 1, 1, 1, 1);
      tf[14] = mkv(5'b00010, 5'b11101, 1, 1, 1, 1);
      tf[15] = mkv(5'b00010, 5'b11101, 1, 1, 1, 1);
      tf[16] = mkv(5'b00011, 5'b11110, 1, 0, 1, 0);  // saturated owner yields at once
      tf[17] = mkv(5'b00000, 5'b11111, 0, 0, 0, 0);

      // Round robin: grants 0,1,2,3,4,0 with each master dropping after its command.
      tr[0] = mkv(5'b11111, 5'b11110, 1, 0, 1, 0);
      tr[1] = mkv(5'b11110, 5'b11101, 1, 1, 1, 1);
      tr[2] = mkv(5'b11101, 5'b11011, 1, 2, 1, 2);
      tr[3] = mkv(5'b11011, 5'b10111, 1, 3, 1, 3);
      tr[4] = mkv(5'b10111, 5'b01111, 1, 4, 1, 4);
      tr[5] = mkv(5'b01111, 5'b11110, 1, 0, 1, 0);
      tr[6] = mkv(5'b00000, 5'b11111, 0, 0, 0, 0);
      tr[7] = mkv(5'b00001, 5'b11110, 1, 0, 1, 0);
      tr[8] = mkv(5'b00010, 5'b11101, 1, 1, 1, 1);   // ch1 left as owner for the reset test

      fresp = '0;
      drive(1'b0, 5'b00000, 0);
      drive(1'b1, 5'b00000, 0);

      // Reset state.
      repeat (2) @(posedge clk);
      #1;
      chk("rst owner_v", 256'({ov_f, ov_r}), 256'(2'b00));
      chk("rst owner", 256'({own_f, own_r}), 256'(6'd0));
      chk("rst fta_req", 256'(freq_f), 256'(0));
      chk("rst misroute", 256'({mis_f, mis_r}), 256'(2'b00));
      @(negedge clk);
      rst = 1'b1;

      for (int k = 0; k < 18; k++) run_row(1'b0, tf[k], k, "fix");
      for (int k = 0; k < 9; k++)  run_row(1'b1, tr[k], k, "rr");

      // Response for ch2 while ch0 owns.
      @(negedge clk);
      drive(1'b0, 5'b00001, 20);
      fresp             = '0;
      fresp.ack         = 1'b1;
      fresp.tid.channel = 3'd2;
      fresp.tid.tranid  = 8'h5A;
      fresp.adr         = 32'hCAFE_0040;
      fresp.dat         = {4{32'h1234_5678}};
      #1;
      chk("route resp2", 256'(resp_f[2]), 256'(fresp));
      chk("route resp0 ack/rty", 256'({resp_f[0].ack, resp_f[0].rty}), 256'(2'b00));
      chk("route resp1 ack/rty", 256'({resp_f[1].ack, resp_f[1].rty}), 256'(2'b01));
      @(posedge clk);
      #1;
      chk("route misroute", 256'(mis_f), 256'(0));
      chk("route fta_req", 256'(freq_f), 256'(mk_req(0, 20, 1'b1)));

      // Misrouted ack (channel 6 of 5).
      @(negedge clk);
      fresp.tid.channel = 3'd6;
      #1;
      for (int i = 0; i < NCH; i++) acks[i] = resp_f[i].ack;
      chk("misroute no ack", 256'(acks), 256'(0));
      @(posedge clk);
      #1;
      chk("misroute pulse", 256'({mis_f, mis_r}), 256'(2'b11));
      @(negedge clk);
      fresp = '0;
      @(posedge clk);
      #1;
      chk("misroute clear", 256'({mis_f, mis_r}), 256'(2'b00));

      // Downstream stall passes through and the command is not forwarded.
      @(negedge clk);
      fresp.rty = 1'b1;
      #1;
      chk("stall rty0", 256'(resp_f[0].rty), 256'(1));
      @(posedge clk);
      #1;
      chk("stall fta_req", 256'(freq_f), 256'(0));
      @(negedge clk);
      fresp.rty = 1'b0;
      @(posedge clk);
      #1;
      chk("unstall fta_req", 256'(freq_f), 256'(mk_req(0, 20, 1'b1)));
      chk("unstall owner", 256'({ov_f, own_f}), 256'({1'b1, 3'd0}));

      // Reset mid-burst with ch1 owning the round-robin instance.
      @(negedge clk);
      rst = 1'b0;
      #1;
      chk("midrst fta_req", 256'(freq_r), 256'(0));
      chk("midrst owner_v", 256'({ov_r, ov_f}), 256'(2'b00));
      @(negedge clk);
      rst = 1'b1;
      drive(1'b1, 5'b00011, 30);
      #1;
      for (int i = 0; i < NCH; i++) acks[i] = resp_r[i].rty;
      chk("postrst rty", 256'(acks), 256'(5'b11110));
      @(posedge clk);
      #1;
      chk("postrst owner", 256'({ov_r, own_r}), 256'({1'b1, 3'd0}));
      chk("postrst fta_req", 256'(freq_r), 256'(mk_req(0, 30, 1'b1)));

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
